mem_dma_engine: RTL and testbench

Bus-initiator block that performs word block-copy and block-fill transactions on the unified memory / memory-mapped I/O bus (memread, memwrite, addr, writedata, readdata) on behalf of the CPU or a debug loader. It requests the bus through a simple req/gnt handshake with the top-level arbiter. It issues memory accesses only while granted, and reports completion with a one-cycle pulse.

---
 rtl/mem_dma_engine.sv | 79 +++++++
 tb/tb_mem_dma_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma_engine.sv
// mem_dma_engine: word block-copy / block-fill bus initiator with req/gnt arbitration
module mem_dma_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             memread,
  output logic             memwrite,
  output logic [31:0]      addr,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata
);
  typedef enum logic [2:0] {IDLE, RD, WR, FILL, FIN} state_t;
  state_t r_state, w_next;
  logic [31:0] r_src, r_dst, r_data, r_fill;
  logic [LEN_W-1:0] r_rem, r_words;
  logic w_last;
  assign w_last = r_rem == LEN_W'(1);
  assign busy = r_state == RD || r_state == WR || r_state == FILL;
  assign done = r_state == FIN;
  assign bus_req = busy;
  assign words_done = r_words;
  assign memread = r_state == RD && bus_gnt;
  assign memwrite = (r_state == WR || r_state == FILL) && bus_gnt;
  assign addr = memread ? r_src : memwrite ? r_dst : '0;
  assign writedata = !memwrite ? '0 : r_state == WR ? r_data : r_fill;
  // state register
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // next state: every bus state holds while the grant is withheld
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = !start ? IDLE : len_words == '0 ? FIN : mode ? FILL : RD;
      RD: w_next = bus_gnt ? WR : RD;
      WR: w_next = !bus_gnt ? WR : w_last ? FIN : RD;
      FILL: w_next = bus_gnt && w_last ? FIN : FILL;
      default: w_next = IDLE;
    endcase
  end
  // command latch and per-word address/count updates, advancing only on granted strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src <= '0;
      r_dst <= '0;
      r_data <= '0;
      r_fill <= '0;
      r_rem <= '0;
      r_words <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_src <= src_addr & ~32'd3;
        r_dst <= dst_addr & ~32'd3;
        r_fill <= fill_value;
        r_rem <= len_words;
        r_words <= '0;
      end
      if (memread) begin
        r_data <= readdata;
        r_src <= r_src + 32'd4;
      end
      if (memwrite) begin
        r_dst <= r_dst + 32'd4;
        r_rem <= r_rem - LEN_W'(1);
        r_words <= r_words + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_dma_engine.sv
// tb_mem_dma_engine: scoreboard bench with word-level reference model and random grant
module tb_mem_dma_engine;
  localparam int LEN_W = 16;
  logic clk = 0, reset = 1, start = 0, mode = 0, bus_gnt = 1;
  logic [31:0] src_addr = 0, dst_addr = 0, fill_value = 0;
  logic [LEN_W-1:0] len_words = 0;
  logic busy, done, bus_req, memread, memwrite;
  logic [LEN_W-1:0] words_done;
  logic [31:0] addr, writedata, readdata;
  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t wq[$];
  wr_t mexp;
  int dq[$];
  int checks = 0, failures = 0, nreads = 0, nwrites = 0;
  bit rnd_gnt = 0;

  mem_dma_engine #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src_addr(src_addr),
    .dst_addr(dst_addr), .len_words(len_words), .fill_value(fill_value), .busy(busy),
    .done(done), .words_done(words_done), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .memread(memread), .memwrite(memwrite), .addr(addr), .writedata(writedata),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  // memory device: combinational read, write commits on the clock edge
  assign readdata = ram[addr[11:2]];
  always @(posedge clk) if (memwrite) ram[addr[11:2]] = writedata;

  // random grant generator for the soak phase
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_gnt) bus_gnt = $urandom_range(0, 3) != 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor: bus rules, write scoreboard, completion scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      chk("bus_rules", 32'({memread && memwrite, (memread || memwrite) && !bus_gnt,
          bus_req != busy, !(memread || memwrite) && (addr != 0 || writedata != 0)}), 32'd0);
      if (memread) nreads++;
      if (memwrite) begin
        nwrites++;
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%h data=%h required=none", addr, writedata);
        end else begin
          mexp = wq.pop_front();
          chk("wr_addr", addr, mexp.a);
          chk("wr_data", writedata, mexp.d);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done words_done=%0d required=none", words_done);
        end else begin
          chk("words_done", 32'(words_done), 32'(dq.pop_front()));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // drive a command; the model predicts the first nexp writes and updates its memory image
  task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d, input int n,
                       input logic [31:0] f, input int nexp, input bit exp_done);
    logic [31:0] sa, da, v;
    @(posedge clk);
    #1;
    start = 1;
    mode = m;
    src_addr = s;
    dst_addr = d;
    len_words = n[LEN_W-1:0];
    fill_value = f;
    for (int i = 0; i < nexp; i++) begin
      sa = (s & ~32'd3) + 32'(4 * i);
      da = (d & ~32'd3) + 32'(4 * i);
      v = m ? f : ref_mem[sa[11:2]];
      wq.push_back('{da, v});
      ref_mem[da[11:2]] = v;
    end
    if (exp_done) dq.push_back(n);
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_done(input int c0, input int exp);
    int c = c0;
    bit got = 0;
    while (!got && c < c0 + 4000) begin
      @(negedge clk);
      if (done) got = 1;
      else c++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=cycle %0d", exp);
    end else if (exp >= 0) chk("done_cycle", 32'(c), 32'(exp));
  endtask

  initial begin
    int w0, r0, bad;
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    ram[0] = 32'h11;
    ram[1] = 32'h22;
    ram[2] = 32'h33;
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_memread", 32'(memread), 32'd0);
    chk("rst_memwrite", 32'(memwrite), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    // fill 4 words at 0x100
    w0 = nwrites;
    issue(1, 32'h0, 32'h100, 4, 32'hA5A5A5A5, 4, 1);
    wait_done(1, 5);
    chk("fill_writes", 32'(nwrites - w0), 32'd4);
    for (int i = 64; i < 68; i++) chk("fill_ram", ram[i], 32'hA5A5A5A5);
    // copy 3 words 0x0 -> 0x200
    r0 = nreads;
    issue(0, 32'h0, 32'h200, 3, 32'h0, 3, 1);
    wait_done(1, 7);
    chk("copy_reads", 32'(nreads - r0), 32'd3);
    chk("copy_ram0", ram[128], 32'h11);
    chk("copy_ram1", ram[129], 32'h22);
    chk("copy_ram2", ram[130], 32'h33);
    // copy 2 words with grant withheld in cycles 2 and 3
    issue(0, 32'h40, 32'h300, 2, 32'h0, 2, 1);
    @(posedge clk);
    #1;
    bus_gnt = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus_gnt = 1;
    wait_done(4, 7);
    // zero-length command
    w0 = nwrites;
    r0 = nreads;
    issue(0, 32'h0, 32'h80, 0, 32'h0, 0, 1);
    wait_done(1, 1);
    chk("len0_strobes", 32'(nwrites - w0 + nreads - r0), 32'd0);
    // second start while a fill is running
    w0 = nwrites;
    issue(1, 32'h0, 32'h400, 4, 32'hDEADBEEF, 4, 1);
    @(posedge clk);
    #1;
    start = 1;
    mode = 0;
    len_words = 7;
    dst_addr = 32'h600;
    @(posedge clk);
    #1;
    start = 0;
    wait_done(3, 5);
    chk("busy_start_writes", 32'(nwrites - w0), 32'd4);
    // unaligned destination wrapping past the top of the address space
    issue(1, 32'h0, 32'hFFFFFFFE, 2, 32'h5A5A0001, 2, 1);
    wait_done(1, 3);
    // reset during WR of word 2 of a 4-word copy
    w0 = nwrites;
    issue(0, 32'h800, 32'hA00, 4, 32'h0, 1, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1;
    bus_gnt = 0;
    @(posedge clk);
    #1;
    bus_gnt = 1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_strobes", 32'({memread, memwrite}), 32'd0);
    chk("abort_addr", addr, 32'd0);
    chk("abort_words_done", 32'(words_done), 32'd0);
    chk("abort_writes", 32'(nwrites - w0), 32'd1);
    @(posedge clk);
    #1;
    reset = 0;
    issue(0, 32'h800, 32'hC00, 3, 32'h0, 3, 1);
    wait_done(1, 7);
    // random soak with random grant
    rnd_gnt = 1;
    for (int k = 0; k < 25; k++) begin
      int n;
      logic m;
      n = $urandom_range(0, 10);
      m = 1'($urandom_range(0, 1));
      issue(m, $urandom, $urandom, n, $urandom, n, 1);
      wait_done(1, -1);
    end
    @(posedge clk);
    rnd_gnt = 0;
    #1;
    bus_gnt = 1;
    repeat (2) @(posedge clk);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_image", 32'(bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
